wb_burst_ram: RTL and testbench
===============================

// Module: wb_burst_ram
// PURPOSE
//   Wishbone B4 single-port block RAM slave with registered-feedback burst
//   support (CTI/BTE), byte lanes, base-address decode and error response.
//   Parametrised successor to the classic-cycle block RAM. Sits on the SoC
//   Wishbone bus as sample/descriptor buffer memory for the S/PDIF datapath.
//   Sustains one beat per clock inside bursts.
// PARAMETERS
//   ADDR_WIDTH  14         word address bits; depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  32         data width; must be a multiple of 8 (8..64)
//   SEL_WIDTH   DATA_WIDTH/8  byte lanes
//   BASE_ADDR   32'h0      byte base address; aligned to the region size
// PORTS
//   wb_clk_i    in   1           clock; all logic on rising edge
//   wb_rst_n_i  in   1           reset, asynchronous assert, active-low
//   wb_cyc_i    in   1           bus cycle in progress
//   wb_stb_i    in   1           strobe; beat valid
//   wb_we_i     in   1           1 = write, 0 = read
//   wb_sel_i    in   SEL_WIDTH   byte enables; bit i covers dat[8i+7:8i]
//   wb_adr_i    in   32          byte address
//   wb_dat_i    in   DATA_WIDTH  write data
//   wb_cti_i    in   3           000 classic, 010 incr burst, 111 end-of-burst
//   wb_bte_i    in   2           00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wb_dat_o    out  DATA_WIDTH  read data; full word, independent of sel
//   wb_ack_o    out  1           beat acknowledge
//   wb_err_o    out  1           error acknowledge
// BEHAVIOUR
//   - Reset (wb_rst_n_i=0): state=IDLE, ack_r=0, err_r=0, wb_dat_o=0.
//     Memory contents are not cleared. Reset mid-burst aborts the burst;
//     no write commits after assertion.
//   - LSB = log2(SEL_WIDTH). Word index = wb_adr_i[ADDR_WIDTH+LSB-1:LSB].
//     In range iff wb_adr_i[31:ADDR_WIDTH+LSB] == BASE_ADDR[31:ADDR_WIDTH+LSB].
//   - wb_ack_o = ack_r & wb_cyc_i & wb_stb_i; wb_err_o = err_r & wb_cyc_i & wb_stb_i.
//   - A beat completes at the rising edge where wb_ack_o=1.
//   - Writes commit only at a completing edge with wb_we_i=1, and only to
//     lanes with wb_sel_i=1. Unselected lanes keep their old value.
//   - Reads: the RAM is read one cycle ahead, so wb_dat_o is valid whenever
//     wb_ack_o=1.
//   - FSM states: IDLE, BURST, DONE.
//   - IDLE:
//     . cyc&stb, out of range: err_r=1 for 1 cycle, no access, -> DONE.
//     . cyc&stb, in range: latch word index into addr_r; read RAM[index];
//       ack_r=1; -> BURST if cti==010, else -> DONE after the first beat.
//     . Latency: ack 1 cycle after stb, i.e. classic access = 2 cycles.
//   - BURST, at each completing edge:
//     . Next address = addr_r+1, confined by bte: wrap4/8/16 replaces only
//       the low 2/3/4 index bits (mod 4/8/16); linear wraps mod depth with
//       no error.
//     . RAM is read at the next address; ack_r stays 1.
//     . Completing beat with cti!=010 (111 or any other) ends the burst:
//       ack_r=0, -> DONE.
//     . stb=0 (master wait state): wb_ack_o=0, addr_r held, no commit;
//       resumes the cycle stb returns.
//   - DONE: ack_r=0, err_r=0 for exactly 1 cycle; stb is ignored, so a
//     strobe still held does not restart the access. -> IDLE.
//   - wb_cyc_i=0 in any state: -> IDLE, ack_r=0, err_r=0, no commit.
//   - Simultaneous ack and err never occur.
// TESTING
//   1. Classic write 0xDEADBEEF, sel=1111, @BASE+0x10, then classic read:
//      ack 1 cycle after stb each access; read returns 0xDEADBEEF;
//      stb held through DONE causes no second access.
//   2. sel=0010 write 0x0000AA00 over 0x11223344: read returns 0x1122AA44.
//   3. Incr linear read burst of 8 from word 0x3FFC, ADDR_WIDTH=14: ack on
//      8 consecutive cycles; data from words 3FFC..3FFF,0000..0003.
//   4. Wrap4 write burst starting word 6 (data 1,2,3,4): words 6,7,4,5 hold
//      1,2,3,4; cti=111 on beat 4 -> ack drops the next cycle.
//   5. Access @BASE+4*2**ADDR_WIDTH: err 1 cycle, ack stays 0, memory
//      unchanged; stb=0 for 2 cycles mid-burst: no ack, no skipped address.
//   6. cyc dropped, then reset asserted, mid write burst: no further commits;
//      outputs 0 during reset; next classic read succeeds.

Source files
------------

// File: rtl/wb_burst_ram.sv
// ---------------------------------------------------------------------------
// wb_burst_ram
//   Wishbone B4 single-port RAM slave. Supports classic cycles and
//   registered-feedback incrementing bursts (linear / wrap4 / wrap8 / wrap16),
//   per-byte write enables, base-address decode with an error response for
//   out-of-range accesses, and one beat per clock inside a burst.
//
// Ports
//   wb_clk_i    clock, rising edge
//   wb_rst_n_i  asynchronous active-low reset
//   wb_cyc_i    bus cycle in progress
//   wb_stb_i    beat strobe
//   wb_we_i     1 = write, 0 = read
//   wb_sel_i    byte lane enables
//   wb_adr_i    byte address
//   wb_dat_i    write data
//   wb_cti_i    cycle type (000 classic, 010 incr burst, 111 end of burst)
//   wb_bte_i    burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wb_dat_o    read data, full word
//   wb_ack_o    beat acknowledge
//   wb_err_o    error acknowledge
// ---------------------------------------------------------------------------
module wb_burst_ram #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 32,
  parameter int          SEL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o
);

  localparam int LSB    = $clog2(SEL_WIDTH);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int TAGLSB = ADDR_WIDTH + LSB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_ack;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_hit;
  logic [ADDR_WIDTH-1:0]   w_wrap_mask;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [ADDR_WIDTH-1:0]   w_next_idx;
  logic                    w_commit;
  logic [31:0]             w_unused_adr;

  // The byte-offset bits below the word index carry no information here.
  assign w_unused_adr = wb_adr_i;

  assign w_idx = wb_adr_i[TAGLSB-1:LSB];
  assign w_hit = (wb_adr_i[31:TAGLSB] == BASE_ADDR[31:TAGLSB]);

  assign wb_ack_o = r_ack & wb_cyc_i & wb_stb_i;
  assign wb_err_o = r_err & wb_cyc_i & wb_stb_i;
  assign wb_dat_o = r_dat;

  // A write lands only on an acknowledged beat; ack is forced low by reset
  // and by a dropped cycle, which blocks commits in both cases.
  assign w_commit = wb_ack_o & wb_we_i;

  // Burst address generator: wrap modes replace only the low index bits.
  always_comb begin
    w_wrap_mask = '1;
    case (wb_bte_i)
      2'b00:   w_wrap_mask = '1;
      2'b01:   w_wrap_mask = ADDR_WIDTH'(32'd3);
      2'b10:   w_wrap_mask = ADDR_WIDTH'(32'd7);
      2'b11:   w_wrap_mask = ADDR_WIDTH'(32'd15);
      default: w_wrap_mask = '1;
    endcase
    w_addr_inc = r_addr + ADDR_WIDTH'(32'd1);
    w_next_idx = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
  end

  // Memory array write port with byte-lane enables.
  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (w_commit && wb_sel_i[i]) begin
        r_mem[r_addr][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  // Bus FSM with the read-ahead data register.
  // A classic access also spends its single ack beat in ST_BURST: with
  // cti != 010 the first completing beat ends it, exactly like an
  // end-of-burst beat, so both paths share the same exit logic.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else if (!wb_cyc_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wb_stb_i) begin
            if (w_hit) begin
              r_addr  <= w_idx;
              r_dat   <= r_mem[w_idx];
              r_ack   <= 1'b1;
              r_state <= ST_BURST;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_BURST: begin
          // r_ack is always set here, so stb alone marks a completing beat;
          // stb low is a master wait state and holds everything.
          if (wb_stb_i) begin
            if (wb_cti_i == 3'b010) begin
              r_addr <= w_next_idx;
              r_dat  <= r_mem[w_next_idx];
            end else begin
              r_ack   <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Guard cycle: a strobe still held here must not restart.
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_ram
//   Directed self-checking bench for wb_burst_ram (ADDR_WIDTH=14, 32-bit
//   data, base 0x0001_0000). Inputs change on the falling edge and outputs
//   are sampled on the falling edge (or 1 ns after an input change).
// ---------------------------------------------------------------------------
module tb_wb_burst_ram;

  localparam int          AW   = 14;
  localparam int          DW   = 32;
  localparam int          SW   = 4;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc, stb, we;
  logic [SW-1:0] sel;
  logic [31:0]   adr;
  logic [DW-1:0] dat_w;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_r;
  logic          ack, err;

  int n_checks = 0;
  int n_fail   = 0;

  wb_burst_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SEL_WIDTH (SW),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_err_o  (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] badr(input int w);
    return BASE + (32'(w) << 2);
  endfunction

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; cti = 3'b000; bte = 2'b00;
  endtask

  // Classic access started at a falling edge with the slave idle. Ack is
  // expected one cycle after stb; stb is held through the guard cycle.
  task automatic classic(input string tag, input logic we_v, input int w,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic chk_rd, input logic [31:0] exp_rd);
    cyc = 1'b1; stb = 1'b1; we = we_v; adr = badr(w); sel = s; dat_w = d;
    cti = 3'b000; bte = 2'b00;
    #1 check_eq({tag, " ack_t0"}, 32'(ack), 32'd0);
    @(negedge clk);
    check_eq({tag, " ack_t1"}, 32'(ack), 32'd1);
    if (chk_rd) check_eq({tag, " rdata"}, dat_r, exp_rd);
    @(negedge clk);
    check_eq({tag, " ack_done"}, 32'(ack), 32'd0);
    @(negedge clk);
    check_eq({tag, " no_restart"}, 32'(ack), 32'd0);
    bus_idle();
  endtask

  logic [31:0] exp_v [0:7];

  initial begin
    bus_idle();

    // Reset state
    @(negedge clk);
    check_eq("rst ack", 32'(ack), 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    check_eq("rst dat", dat_r, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Classic write then read at BASE+0x10 (word 4)
    classic("t1 wr", 1'b1, 4, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
    classic("t1 rd", 1'b0, 4, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // 2. Byte-lane merge on word 5
    classic("t2 wr0", 1'b1, 5, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
    classic("t2 wr1", 1'b1, 5, 4'b0010, 32'h0000_AA00, 1'b0, 32'h0);
    classic("t2 rd", 1'b0, 5, 4'hF, 32'h0, 1'b1, 32'h1122_AA44);

    // 3. Linear read burst of 8 across the top of memory
    for (int k = 0; k < 8; k++) begin
      exp_v[k] = 32'hB000_0000 | ((32'h3FFC + 32'(k)) & 32'h3FFF);
      classic("t3 fill", 1'b1, int'((32'h3FFC + 32'(k)) & 32'h3FFF), 4'hF,
              exp_v[k], 1'b0, 32'h0);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = badr(32'h3FFC);
    cti = 3'b010; bte = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("t3 ack b%0d", k), 32'(ack), 32'd1);
      check_eq($sformatf("t3 dat b%0d", k), dat_r, exp_v[k]);
      if (k == 7) cti = 3'b111;
    end
    @(negedge clk);
    check_eq("t3 ack end", 32'(ack), 32'd0);
    bus_idle();
    @(negedge clk);

    // 4. Wrap4 write burst from word 6: order 6,7,4,5
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = badr(6);
    cti = 3'b010; bte = 2'b01; dat_w = 32'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("t4 ack b%0d", k), 32'(ack), 32'd1);
      dat_w = 32'(k + 1);
      cti = (k == 3) ? 3'b111 : 3'b010;
    end
    @(negedge clk);
    check_eq("t4 ack drop", 32'(ack), 32'd0);
    bus_idle();
    @(negedge clk);
    classic("t4 rd6", 1'b0, 6, 4'hF, 32'h0, 1'b1, 32'd1);
    classic("t4 rd7", 1'b0, 7, 4'hF, 32'h0, 1'b1, 32'd2);
    classic("t4 rd4", 1'b0, 4, 4'hF, 32'h0, 1'b1, 32'd3);
    classic("t4 rd5", 1'b0, 5, 4'hF, 32'h0, 1'b1, 32'd4);

    // 5a. Out-of-range write (aliases word 0 if decode were wrong)
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = BASE + 32'h0001_0000; dat_w = 32'hBADB_AD00;
    #1 check_eq("t5 err t0", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("t5 err t1", 32'(err), 32'd1);
    check_eq("t5 ack t1", 32'(ack), 32'd0);
    @(negedge clk);
    check_eq("t5 err t2", 32'(err), 32'd0);
    check_eq("t5 ack t2", 32'(ack), 32'd0);
    bus_idle();
    @(negedge clk);
    classic("t5 mem0", 1'b0, 0, 4'hF, 32'h0, 1'b1, 32'hB000_0000);

    // 5b. Read burst 3FFE,3FFF,0,1 with two wait states after beat 1
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = badr(32'h3FFE);
    cti = 3'b010; bte = 2'b00;
    @(negedge clk);
    check_eq("t5w ack b0", 32'(ack), 32'd1);
    check_eq("t5w dat b0", dat_r, 32'hB000_3FFE);
    @(negedge clk);
    check_eq("t5w ack b1", 32'(ack), 32'd1);
    check_eq("t5w dat b1", dat_r, 32'hB000_3FFF);
    @(negedge clk);
    stb = 1'b0;
    #1 check_eq("t5w ack ws1", 32'(ack), 32'd0);
    @(negedge clk);
    check_eq("t5w ack ws2", 32'(ack), 32'd0);
    @(negedge clk);
    stb = 1'b1;
    #1 check_eq("t5w ack b2", 32'(ack), 32'd1);
    check_eq("t5w dat b2", dat_r, 32'hB000_0000);
    @(negedge clk);
    cti = 3'b111;
    check_eq("t5w ack b3", 32'(ack), 32'd1);
    check_eq("t5w dat b3", dat_r, 32'hB000_0001);
    @(negedge clk);
    check_eq("t5w ack end", 32'(ack), 32'd0);
    bus_idle();
    @(negedge clk);

    // 6a. cyc dropped mid write burst over words 0x100..
    for (int k = 0; k < 4; k++)
      classic("t6 fill", 1'b1, 32'h100 + k, 4'hF, 32'h5000_0000 | 32'(k), 1'b0, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = badr(32'h100);
    cti = 3'b010; bte = 2'b00; dat_w = 32'h600;
    @(negedge clk);
    check_eq("t6 ack b0", 32'(ack), 32'd1);
    @(negedge clk);
    check_eq("t6 ack b1", 32'(ack), 32'd1);
    dat_w = 32'h601;
    @(negedge clk);
    dat_w = 32'h602;
    cyc = 1'b0;
    #1 check_eq("t6 ack cyc0", 32'(ack), 32'd0);
    @(negedge clk);
    check_eq("t6 ack idle", 32'(ack), 32'd0);
    bus_idle();
    classic("t6 rd100", 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h600);
    classic("t6 rd101", 1'b0, 32'h101, 4'hF, 32'h0, 1'b1, 32'h601);
    classic("t6 rd102", 1'b0, 32'h102, 4'hF, 32'h0, 1'b1, 32'h5000_0002);

    // 6b. Reset asserted mid write burst
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = badr(32'h100);
    cti = 3'b010; bte = 2'b00; dat_w = 32'h700;
    @(negedge clk);
    check_eq("t6r ack b0", 32'(ack), 32'd1);
    @(negedge clk);
    dat_w = 32'h701;
    rst_n = 1'b0;
    #1 check_eq("t6r ack rst", 32'(ack), 32'd0);
    check_eq("t6r err rst", 32'(err), 32'd0);
    check_eq("t6r dat rst", dat_r, 32'd0);
    @(negedge clk);
    check_eq("t6r ack hold", 32'(ack), 32'd0);
    check_eq("t6r dat hold", dat_r, 32'd0);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    classic("t6r rd101", 1'b0, 32'h101, 4'hF, 32'h0, 1'b1, 32'h601);
    classic("t6r rd100", 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h700);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
